alu_op_driver: RTL and testbench
================================

ALU_OP_DRIVER -- requirements
Module: alu_op_driver

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock, all state updates on it.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: req_valid  in  1  request offered; req_ready  out  1  driver can accept.
REQ-004 SHALL have: alu_op  in  2  main-control ALUOp; funct  in  6  R-type funct field.
REQ-005 SHALL have: src_a  in  32  operand A; src_b  in  32  operand B.
REQ-006 SHALL have: alu_a  out  32; alu_b  out  32; alu_ctrl  out  4  (drive the ALU a, b, ctrl).
REQ-007 SHALL have: alu_out  in  32; alu_zero  in  1; alu_overflow  in  1  (combinational ALU results).
REQ-008 SHALL have: rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-009 SHALL have: rsp_result  out  32; rsp_zero  out  1; rsp_overflow  out  1; rsp_illegal  out  1.

Function
REQ-010 SHALL implement FSM states IDLE, EXEC, RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-011 SHALL accept a request in IDLE when req_valid=1 (transfer cycle N) and decode alu_op/funct that cycle.
REQ-012 SHALL decode: alu_op 00 -> 0010 (ADD); 01 -> 0110 (SUB); 11 -> illegal.
REQ-013 SHALL decode alu_op 10 by funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111, 100111 -> 1100; any other funct -> illegal.
REQ-014 Legal request SHALL register src_a, src_b and decoded ctrl into alu_a, alu_b, alu_ctrl at end of cycle N and go to EXEC.
REQ-015 alu_a, alu_b, alu_ctrl SHALL hold their values until the next legal acceptance (stable through EXEC and RESP).
REQ-016 In EXEC (one cycle) SHALL capture alu_out, alu_zero, alu_overflow into rsp_result, rsp_zero, rsp_overflow, set rsp_illegal=0, go to RESP; rsp_valid first high at cycle N+2.
REQ-017 Illegal request SHALL leave alu_a/alu_b/alu_ctrl unchanged, set rsp_result=0, rsp_zero=0, rsp_overflow=0, rsp_illegal=1, and go directly to RESP; rsp_valid first high at N+1.
REQ-018 In RESP all rsp_* outputs SHALL remain stable while rsp_ready=0, for any number of cycles.
REQ-019 In RESP with rsp_ready=1 SHALL return to IDLE next cycle; no request accepted in that same cycle (req_ready=0); minimum spacing 3 cycles legal, 2 illegal.
REQ-020 req_valid asserted outside IDLE SHALL be ignored; requester holds it until req_ready=1.
REQ-021 rsp_overflow SHALL be passed from the ALU only for ADD/SUB ctrl codes; forced 0 for AND, OR, SLT, NOR.

Reset
REQ-022 reset=1 SHALL, at the next clk edge, force state IDLE and all outputs to 0 (alu_a, alu_b, alu_ctrl=0000, rsp_*=0, rsp_valid=0), except req_ready=1 after the reset edge.
REQ-023 reset asserted in EXEC or RESP SHALL discard the in-flight operation; no response is produced for it.
REQ-024 reset SHALL take priority over req_valid and rsp_ready in the same cycle.

Configuration
REQ-025 Macro ALU_UNSIGNED_OPS_EN SHALL control unsigned arithmetic decode.
REQ-026 With ALU_UNSIGNED_OPS_EN defined: alu_op 10 with funct 100001 -> 0010, 100011 -> 0110, rsp_overflow forced 0 for these.
REQ-027 Without ALU_UNSIGNED_OPS_EN: funct 100001 and 100011 SHALL be illegal per REQ-017.

Verification
REQ-028 Reset 2 cycles then release -> req_ready=1, rsp_valid=0, alu_ctrl=0000, alu_a=alu_b=0, rsp_*=0.
REQ-029 alu_op=10, funct=100000, a=0x7FFFFFFF, b=1 accepted at N -> alu_ctrl=0010 at N+1; rsp_valid at N+2 with rsp_result=0x80000000, rsp_overflow=1, rsp_zero=0.
REQ-030 alu_op=01, a=5, b=5 -> alu_ctrl=0110, rsp_result=0, rsp_zero=1, rsp_overflow=0; then alu_op=10, funct=101010, a=-3, b=2 -> alu_ctrl=0111, rsp_result=1, rsp_overflow=0.
REQ-031 NOR a=0, b=0, rsp_ready held 0 for 5 cycles -> rsp_result=0xFFFFFFFF stable, req_ready=0 throughout; rsp_ready=1 -> IDLE next cycle.
REQ-032 alu_op=10, funct=001000 -> rsp_valid at N+1, rsp_illegal=1, rsp_result=0, alu_ctrl/alu_a/alu_b unchanged from previous op.
REQ-033 reset pulsed in EXEC -> no rsp_valid; next legal request completes normally; with ALU_UNSIGNED_OPS_EN, funct 100001, a=0x7FFFFFFF, b=1 -> rsp_result=0x80000000, rsp_overflow=0; without -> rsp_illegal=1.

Source files
------------

// File: rtl/alu_op_driver.sv
// ALU operand/control driver: accepts a decode request, drives a combinational ALU, returns a registered response.
// Optional build macro ALU_UNSIGNED_OPS_EN enables the unsigned ADDU/SUBU funct decodes.
module alu_op_driver (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_overflow,
  output logic        rsp_illegal
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  localparam logic [CW-1:0] CTRL_AND = 4'b0000;
  localparam logic [CW-1:0] CTRL_OR  = 4'b0001;
  localparam logic [CW-1:0] CTRL_ADD = 4'b0010;
  localparam logic [CW-1:0] CTRL_SUB = 4'b0110;
  localparam logic [CW-1:0] CTRL_SLT = 4'b0111;
  localparam logic [CW-1:0] CTRL_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   alu_a_q, alu_a_d;
  logic [DW-1:0]   alu_b_q, alu_b_d;
  logic [CW-1:0]   alu_ctrl_q, alu_ctrl_d;
  logic            ovf_en_q, ovf_en_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_result_q, rsp_result_d;
  logic            rsp_zero_q, rsp_zero_d;
  logic            rsp_overflow_q, rsp_overflow_d;
  logic            rsp_illegal_q, rsp_illegal_d;

  logic [CW-1:0]   dec_ctrl_c;
  logic            dec_illegal_c;
  logic            dec_ovf_en_c;
  logic            accept_c;

  // ALUOp/funct decode; overflow is only meaningful for signed ADD/SUB
  always_comb begin
    dec_ctrl_c    = CTRL_AND;
    dec_illegal_c = 1'b0;
    dec_ovf_en_c  = 1'b0;
    case (alu_op)
      2'b00: begin dec_ctrl_c = CTRL_ADD; dec_ovf_en_c = 1'b1; end
      2'b01: begin dec_ctrl_c = CTRL_SUB; dec_ovf_en_c = 1'b1; end
      2'b10: begin
        case (funct)
          6'b100000: begin dec_ctrl_c = CTRL_ADD; dec_ovf_en_c = 1'b1; end
          6'b100010: begin dec_ctrl_c = CTRL_SUB; dec_ovf_en_c = 1'b1; end
          6'b100100: dec_ctrl_c = CTRL_AND;
          6'b100101: dec_ctrl_c = CTRL_OR;
          6'b101010: dec_ctrl_c = CTRL_SLT;
          6'b100111: dec_ctrl_c = CTRL_NOR;
`ifdef ALU_UNSIGNED_OPS_EN
          6'b100001: dec_ctrl_c = CTRL_ADD;
          6'b100011: dec_ctrl_c = CTRL_SUB;
`endif
          default:   dec_illegal_c = 1'b1;
        endcase
      end
      default: dec_illegal_c = 1'b1;
    endcase
  end

  assign accept_c = (state_q == IDLE) && req_valid;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) state_d = dec_illegal_c ? RESP : EXEC;
      EXEC: state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath logic; everything holds unless explicitly loaded
  always_comb begin
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_ctrl_d     = alu_ctrl_q;
    ovf_en_d       = ovf_en_q;
    rsp_result_d   = rsp_result_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_illegal_d  = rsp_illegal_q;
    req_ready_d    = (state_d == IDLE);
    rsp_valid_d    = (state_d == RESP);

    if (accept_c) begin
      if (dec_illegal_c) begin
        rsp_result_d   = '0;
        rsp_zero_d     = 1'b0;
        rsp_overflow_d = 1'b0;
        rsp_illegal_d  = 1'b1;
      end else begin
        alu_a_d    = src_a;
        alu_b_d    = src_b;
        alu_ctrl_d = dec_ctrl_c;
        ovf_en_d   = dec_ovf_en_c;
      end
    end

    if (state_q == EXEC) begin
      rsp_result_d   = alu_out;
      rsp_zero_d     = alu_zero;
      rsp_overflow_d = alu_overflow & ovf_en_q;
      rsp_illegal_d  = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_ctrl_q     <= '0;
      ovf_en_q       <= 1'b0;
      req_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_illegal_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_ctrl_q     <= alu_ctrl_d;
      ovf_en_q       <= ovf_en_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_result_q   <= rsp_result_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_illegal_q  <= rsp_illegal_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_ctrl     = alu_ctrl_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_illegal  = rsp_illegal_q;

endmodule

// File: tb/tb_alu_op_driver.sv
// Scoreboard bench for alu_op_driver: directed requests, behavioural ALU, decoupled response monitor.
module tb_alu_op_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  alu_op = 2'b00;
  logic [5:0]  funct = 6'b000000;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_out;
  logic        alu_zero, alu_overflow;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_overflow, rsp_illegal;

  alu_op_driver dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .alu_op(alu_op), .funct(funct), .src_a(src_a), .src_b(src_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .rsp_illegal(rsp_illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU; logic ops report a spurious overflow so the driver's masking is visible
  logic [31:0] sum_c, dif_c;
  always_comb begin
    sum_c = alu_a + alu_b;
    dif_c = alu_a - alu_b;
    alu_out      = '0;
    alu_overflow = 1'b1;
    case (alu_ctrl)
      4'b0010: begin alu_out = sum_c; alu_overflow = (alu_a[31] == alu_b[31]) && (sum_c[31] != alu_a[31]); end
      4'b0110: begin alu_out = dif_c; alu_overflow = (alu_a[31] != alu_b[31]) && (dif_c[31] != alu_a[31]); end
      4'b0000: alu_out = alu_a & alu_b;
      4'b0001: alu_out = alu_a | alu_b;
      4'b0111: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'b1100: alu_out = ~(alu_a | alu_b);
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == 32'd0);
  end

  typedef struct {
    logic [31:0] res;
    logic        z, ov, ill;
    logic [3:0]  ctrl;
    logic [31:0] a, b;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   hold_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response sink: releases rsp_ready after hold_left stalled cycles
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rsp_valid === 1'b1 && rsp_ready == 1'b0) begin
        if (hold_left > 0) hold_left--;
        else rsp_ready = 1'b1;
      end else begin
        rsp_ready = 1'b0;
      end
    end
  end

  // Monitor: stability during stall, latency, scoreboard compare on handshake
  initial begin
    bit          prev_v = 0, prev_hs = 0;
    int          first = 0;
    logic [34:0] snap = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (prev_hs) begin
        chk("idle_after_hs_req_ready", 32'(req_ready), 32'd1);
        chk("idle_after_hs_rsp_valid", 32'(rsp_valid), 32'd0);
      end
      if (rsp_valid === 1'b1) begin
        chk("resp_req_ready_low", 32'(req_ready), 32'd0);
        if (!prev_v) first = cyc;
        else chk("resp_stable", 32'({rsp_result, rsp_zero, rsp_overflow, rsp_illegal} != snap), 32'd0);
        snap = {rsp_result, rsp_zero, rsp_overflow, rsp_illegal};
        if (rsp_ready === 1'b1) begin
          if (sb.size() == 0) begin
            chk("unexpected_response", 32'(rsp_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("latency",      32'(first - e.acc), 32'(e.lat));
            chk("rsp_result",   rsp_result,        e.res);
            chk("rsp_zero",     32'(rsp_zero),     32'(e.z));
            chk("rsp_overflow", 32'(rsp_overflow), 32'(e.ov));
            chk("rsp_illegal",  32'(rsp_illegal),  32'(e.ill));
            chk("alu_ctrl",     32'(alu_ctrl),     32'(e.ctrl));
            chk("alu_a",        alu_a,             e.a);
            chk("alu_b",        alu_b,             e.b);
          end
        end
      end
      prev_v  = (rsp_valid === 1'b1);
      prev_hs = prev_v && (rsp_ready === 1'b1);
    end
  end

  task automatic drive_req(input logic [1:0] op, input logic [5:0] fn,
                           input logic [31:0] a, input logic [31:0] b, output bit ok);
    int n = 0;
    @(negedge clk);
    alu_op = op; funct = fn; src_a = a; src_b = b; req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    ok = (n < 50);
    if (!ok) begin
      chk("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input int hold,
                       input logic [31:0] er, input logic ez, input logic eov, input logic eill,
                       input logic [3:0] ectrl, input logic [31:0] ea, input logic [31:0] eb);
    exp_t e;
    bit   ok;
    drive_req(op, fn, a, b, ok);
    if (ok) begin
      hold_left = hold;
      e.res = er; e.z = ez; e.ov = eov; e.ill = eill;
      e.ctrl = ectrl; e.a = ea; e.b = eb;
      e.lat = eill ? 1 : 2;
      e.acc = cyc;
      @(posedge clk);
      sb.push_back(e);
      #1 req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || req_ready !== 1'b1) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    bit ok;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_req_ready",    32'(req_ready),    32'd1);
    chk("reset_rsp_valid",    32'(rsp_valid),    32'd0);
    chk("reset_alu_ctrl",     32'(alu_ctrl),     32'd0);
    chk("reset_alu_a",        alu_a,             32'd0);
    chk("reset_alu_b",        alu_b,             32'd0);
    chk("reset_rsp_result",   rsp_result,        32'd0);
    chk("reset_rsp_zero",     32'(rsp_zero),     32'd0);
    chk("reset_rsp_overflow", 32'(rsp_overflow), 32'd0);
    chk("reset_rsp_illegal",  32'(rsp_illegal),  32'd0);

    //     op     funct      a             b            hold  result        z  ov ill ctrl     alu_a         alu_b
    issue(2'b10, 6'b100000, 32'h7FFFFFFF, 32'h1,        0,    32'h80000000, 0, 1, 0, 4'b0010, 32'h7FFFFFFF, 32'h1);
    issue(2'b01, 6'b000000, 32'd5,        32'd5,        1,    32'h0,        1, 0, 0, 4'b0110, 32'd5,        32'd5);
    issue(2'b10, 6'b101010, 32'hFFFFFFFD, 32'd2,        0,    32'h1,        0, 0, 0, 4'b0111, 32'hFFFFFFFD, 32'd2);
    issue(2'b10, 6'b100111, 32'h0,        32'h0,        5,    32'hFFFFFFFF, 0, 0, 0, 4'b1100, 32'h0,        32'h0);
    issue(2'b10, 6'b001000, 32'd9,        32'd7,        2,    32'h0,        0, 0, 1, 4'b1100, 32'h0,        32'h0);
    issue(2'b11, 6'b100000, 32'd3,        32'd4,        0,    32'h0,        0, 0, 1, 4'b1100, 32'h0,        32'h0);
    issue(2'b10, 6'b100100, 32'hF0F01234, 32'h0FF0FFFF, 0,    32'h00F01234, 0, 0, 0, 4'b0000, 32'hF0F01234, 32'h0FF0FFFF);
    issue(2'b10, 6'b100101, 32'h000000F0, 32'h0000000F, 1,    32'h000000FF, 0, 0, 0, 4'b0001, 32'h000000F0, 32'h0000000F);
    issue(2'b10, 6'b100010, 32'h80000000, 32'h1,        0,    32'h7FFFFFFF, 0, 1, 0, 4'b0110, 32'h80000000, 32'h1);
    issue(2'b00, 6'b111111, 32'hFFFFFFFF, 32'h1,        0,    32'h0,        1, 0, 0, 4'b0010, 32'hFFFFFFFF, 32'h1);
    wait_idle();

    // Reset during EXEC must discard the operation
    drive_req(2'b01, 6'b000000, 32'd10, 32'd4, ok);
    if (ok) begin
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_exec_req_ready", 32'(req_ready), 32'd1);
      chk("rst_exec_alu_ctrl",  32'(alu_ctrl),  32'd0);
      chk("rst_exec_alu_a",     alu_a,          32'd0);
      for (int i = 0; i < 4; i++) begin
        chk("rst_exec_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
      end
    end

    issue(2'b00, 6'b000000, 32'd2, 32'd3, 0, 32'd5, 0, 0, 0, 4'b0010, 32'd2, 32'd3);
`ifdef ALU_UNSIGNED_OPS_EN
    issue(2'b10, 6'b100001, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 0, 0, 0, 4'b0010, 32'h7FFFFFFF, 32'h1);
    issue(2'b10, 6'b100011, 32'h80000000, 32'h1, 1, 32'h7FFFFFFF, 0, 0, 0, 4'b0110, 32'h80000000, 32'h1);
`else
    issue(2'b10, 6'b100001, 32'h7FFFFFFF, 32'h1, 0, 32'h0, 0, 0, 1, 4'b0010, 32'd2, 32'd3);
    issue(2'b10, 6'b100011, 32'h80000000, 32'h1, 1, 32'h0, 0, 0, 1, 4'b0010, 32'd2, 32'd3);
`endif
    wait_idle();
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
